// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit for the MIPS datapath.
// Multiplies use shift-add, one multiplier bit per cycle. Divides use restoring
// division, one quotient bit per cycle. Both run on magnitudes; a final FIX
// cycle applies sign correction and writes HI/LO.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start, op         - begin operation (IDLE only); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   operandA/B        - rs / rt values (multiplicand/dividend, multiplier/divisor)
//   hiWrite/loWrite   - MTHI / MTLO strobes, data from writeData (IDLE, no start)
//   busy, done        - operation in flight, one-cycle result pulse
//   hi, lo            - HI / LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg;
    logic [1:0]           op_reg;
    logic [WIDTH-1:0]     a_mag_reg, b_mag_reg, a_raw_reg;
    logic                 sign_a_reg, sign_b_reg, b_zero_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 done_reg;

    // Operand magnitudes at start; sign bits only count for MULT/DIV.
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    // One iteration step and the final sign-corrected result.
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   acc_step, prod_fix;
    logic [WIDTH-1:0]     quot, rem, hi_fix, lo_fix;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_reg == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_reg != IDLE);
        done = done_reg;
        hi   = hi_reg;
        lo   = lo_reg;
    end

    always_comb begin
        a_neg = ~op[0] & operandA[WIDTH-1];
        b_neg = ~op[0] & operandB[WIDTH-1];
        a_mag = a_neg ? -operandA : operandA;
        b_mag = b_neg ? -operandB : operandB;
    end

    // acc_reg holds {partial product, multiplier} for multiplies and
    // {partial remainder, dividend -> quotient} for divides.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_mag_reg} : '0);
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_reg};
        if (!op_reg[1])
            acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        else
            acc_step = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
        quot     = acc_reg[WIDTH-1:0];
        rem      = acc_reg[2*WIDTH-1:WIDTH];
        if (!op_reg[1]) begin
            {hi_fix, lo_fix} = prod_fix;
        end else if (b_zero_reg) begin
            hi_fix = a_raw_reg;
            lo_fix = '1;
        end else begin
            // Quotient sign from operand signs; remainder follows dividend.
            lo_fix = (sign_a_reg ^ sign_b_reg) ? -quot : quot;
            hi_fix = sign_a_reg ? -rem : rem;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            op_reg     <= 2'b00;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            a_raw_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            acc_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg    <= '0;
                        op_reg     <= op;
                        a_mag_reg  <= a_mag;
                        b_mag_reg  <= b_mag;
                        a_raw_reg  <= operandA;
                        sign_a_reg <= a_neg;
                        sign_b_reg <= b_neg;
                        b_zero_reg <= (operandB == '0);
                        acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    end else begin
                        if (hiWrite) hi_reg <= writeData;
                        if (loWrite) lo_reg <= writeData;
                    end
                end
                CALC: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    hi_reg   <= hi_fix;
                    lo_reg   <= lo_fix;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + random checks of mult_div_unit with a result
// scoreboard popped on every done pulse.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = '0, operandB = '0, writeData = '0;
    logic        hiWrite = 1'b0, loWrite = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int dc0, n;
    logic [63:0] exp_q[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: native wide arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = '0;
        case (o)
            2'd0: begin q = sa * sb; p = q; end
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Scoreboard: every done pulse pops one expected {hi,lo}.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_count++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_done observed=done expected=no_done");
            end
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                $display("txn %0d hi=%h lo=%h expected=%h", done_count, hi, lo, e);
                checks++;
                assert ({hi, lo} === e) else begin
                    failures++;
                    $error("FAIL result observed=%h expected=%h", {hi, lo}, e);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        @(negedge clk);
        op = o; operandA = a; operandB = b; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || done) && k < 200);
        chk("idle_timeout", 64'(k < 200), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // 1: MULTU max*max, latency and single done
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        dc0 = done_count;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("done_at_busy_drop", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        chk("done_once", 64'(done_count - dc0), 64'd1);

        // 2: MULT signed
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        wait_idle();
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0});
        wait_idle();

        // 3: divides
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_idle();
        issue(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_idle();
        issue(2'd2, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        wait_idle();

        // 4: divide by zero and DIV overflow
        issue(2'd3, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        wait_idle();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        wait_idle();

        // 5: start and MTHI while busy are ignored; MTHI in IDLE works
        issue(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'd1; operandA = 32'd5; operandB = 32'd5;
        hiWrite = 1'b1; writeData = 32'hAABB_CCDD;
        @(negedge clk);
        start = 1'b0; hiWrite = 1'b0; operandA = 32'hDEAD_BEEF;
        wait_idle();
        chk("busy_ignores_writes", {hi, lo}, {32'd2, 32'd14});
        @(negedge clk);
        hiWrite = 1'b1; writeData = 32'hAABB_CCDD;
        @(posedge clk);
        #1 hiWrite = 1'b0;
        chk("mthi_idle", {hi, lo}, {32'hAABB_CCDD, 32'd14});
        @(negedge clk);
        loWrite = 1'b1; writeData = 32'h1111_2222;
        @(posedge clk);
        #1 loWrite = 1'b0;
        chk("mtlo_idle", {hi, lo}, {32'hAABB_CCDD, 32'h1111_2222});
        // MTLO on the same edge as start loses to start
        @(negedge clk);
        loWrite = 1'b1; writeData = 32'h5555_5555;
        op = 2'd1; operandA = 32'd2; operandB = 32'd3; start = 1'b1;
        exp_q.push_back({32'd0, 32'd6});
        @(posedge clk);
        #1 start = 1'b0; loWrite = 1'b0;
        chk("start_beats_mtlo", 64'(lo), 64'h1111_2222);
        wait_idle();

        // Back-to-back: new start accepted while done is high
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        op = 2'd3; operandA = 32'd100; operandB = 32'd7; start = 1'b1;
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_accept", 64'(busy), 64'd1);
        wait_idle();

        // Random operations against the model
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            issue(ro, ra, rb, model(ro, ra, rb));
            wait_idle();
        end

        // 6: reset mid-operation discards the result
        issue(2'd1, 32'd3, 32'd4, {32'd0, 32'd12});
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        dc0 = done_count;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", 64'(done_count - dc0), 64'd0);
        issue(2'd1, 32'd3, 32'd4, {32'd0, 32'd12});
        wait_idle();
        chk("fresh_multu", {hi, lo}, {32'd0, 32'd12});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
